// File: rtl/ring_pkg.sv
// Shared definitions for the token-ring link (transmit and receive sides).
//  - Frame type codes carried in the 3-bit type field.
//  - HDR_W: header length in bits (type + dest + source).
//  - CRC_POLY: CRC-8 generator polynomial x^8+x^2+x+1.
//  - ring_state_t: framing FSM encoding, identical on both link ends.
package ring_pkg;

    localparam logic [2:0] TOKEN  = 3'b111;
    localparam logic [2:0] ACK    = 3'b000;
    localparam logic [2:0] NACK   = 3'b011;
    localparam logic [2:0] DATA_C = 3'b010;
    localparam logic [2:0] DATA_3 = 3'b001;

    localparam int unsigned HDR_W    = 11;
    localparam logic [7:0]  CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StHeader,
        StPayload,
        StCheck,
        StStop
    } ring_state_t;

    function automatic logic type_is_legal(input logic [2:0] t);
        return !(t inside {3'b100, 3'b101, 3'b110});
    endfunction

    function automatic logic type_is_data(input logic [2:0] t);
        return (t == DATA_C) || (t == DATA_3);
    endfunction

endpackage

// File: rtl/ring_crc8.sv
// Serial CRC-8 engine, MSB-first, polynomial CRC_POLY, init 0x00.
// Ports:
//  Clk_R   in   router clock
//  Rst_n   in   asynchronous active-low reset
//  clr     in   synchronous clear to 0x00 (wins over en)
//  en      in   fold bit_in into the running CRC this cycle
//  bit_in  in   next checked bit
//  crc     out  running CRC value
module ring_crc8
    import ring_pkg::*;
(
    input  logic       Clk_R,
    input  logic       Rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic feedback;

    assign feedback = crc[7] ^ bit_in;

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            crc <= 8'h00;
        end else if (clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= {crc[6:0], 1'b0} ^ (feedback ? CRC_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/ring_tx_serializer.sv
// Transmit end of the token-ring link: registers one frame request and shifts it onto the
// ring line MSB first as START | type | dest | NODE_ADDR | payload (data types) | CHECK | STOP,
// each bit held BIT_DIV clocks.
// Build option: TX_CRC8_EN defined -> CHECK is an 8-bit CRC (ring_crc8); otherwise CHECK is a
// single even-parity bit and no CRC logic exists.
// Ports:
//  Clk_R       in   router clock
//  Rst_n       in   asynchronous active-low reset
//  tx_load     in   send request, sampled only while tx_ready=1
//  tx_type     in   frame type (illegal 100/101/110 rejected with tx_err)
//  tx_dest     in   destination node address
//  tx_payload  in   payload for DATA_C/DATA_3
//  tx_ready    out  idle; a load presented now is accepted at the next edge
//  tx_serial   out  ring line, idle high
//  tx_done     out  1-cycle pulse in the final stop-bit cycle
//  tx_err      out  1-cycle pulse after an illegal-type load
module ring_tx_serializer
    import ring_pkg::*;
#(
    parameter logic [3:0]  NODE_ADDR = 4'b0001,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BIT_DIV   = 4
) (
    input  logic              Clk_R,
    input  logic              Rst_n,
    input  logic              tx_load,
    input  logic [2:0]        tx_type,
    input  logic [3:0]        tx_dest,
    input  logic [DATA_W-1:0] tx_payload,
    output logic              tx_ready,
    output logic              tx_serial,
    output logic              tx_done,
    output logic              tx_err
);

    localparam int unsigned BAUD_W = $clog2(BIT_DIV);
    // Must also hold the header count when DATA_W is small.
    localparam int unsigned CNT_W  = ($clog2(DATA_W + 1) > 4) ? $clog2(DATA_W + 1) : 4;

    ring_state_t       state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [HDR_W-1:0]  hdr_sr;
    logic [DATA_W-1:0] pay_sr;
    logic              is_data;

    logic baud_wrap;
    logic accept;
    logic emit_en;   // a checked (header/payload) bit goes onto the line at this edge
    logic emit_bit;
    logic check_bit; // first CHECK bit

    assign baud_wrap = (baud_cnt == BAUD_W'(BIT_DIV - 1));
    assign accept    = tx_ready & tx_load;

`ifdef TX_CRC8_EN
    logic [7:0] crc;
    logic [7:0] chk_sr;

    ring_crc8 u_crc (
        .Clk_R  (Clk_R),
        .Rst_n  (Rst_n),
        .clr    (accept),
        .en     (emit_en),
        .bit_in (emit_bit),
        .crc    (crc)
    );

    assign check_bit = crc[7];
`else
    logic par;

    assign check_bit = par;
`endif

    always_comb begin
        emit_en  = 1'b0;
        emit_bit = hdr_sr[HDR_W-1];
        if (baud_wrap) begin
            case (state)
                StStart: emit_en = 1'b1;
                StHeader: begin
                    if (bit_cnt != CNT_W'(HDR_W)) begin
                        emit_en = 1'b1;
                    end else if (is_data) begin
                        emit_en  = 1'b1;
                        emit_bit = pay_sr[DATA_W-1];
                    end
                end
                StPayload: begin
                    if (bit_cnt != CNT_W'(DATA_W)) begin
                        emit_en  = 1'b1;
                        emit_bit = pay_sr[DATA_W-1];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge Clk_R or negedge Rst_n) begin
        if (!Rst_n) begin
            state     <= StIdle;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            hdr_sr    <= '0;
            pay_sr    <= '0;
            is_data   <= 1'b0;
            tx_ready  <= 1'b1;
            tx_serial <= 1'b1;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
`ifdef TX_CRC8_EN
            chk_sr    <= '0;
`else
            par       <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
`ifndef TX_CRC8_EN
            if (emit_en) par <= par ^ emit_bit;
`endif
            if (accept) begin
                baud_cnt <= '0;
                if (type_is_legal(tx_type)) begin
                    state     <= StStart;
                    tx_serial <= 1'b0;
                    tx_ready  <= 1'b0;
                    bit_cnt   <= '0;
                    hdr_sr    <= {tx_type, tx_dest, NODE_ADDR};
                    pay_sr    <= tx_payload;
                    is_data   <= type_is_data(tx_type);
`ifndef TX_CRC8_EN
                    par       <= 1'b0;
`endif
                end else begin
                    state     <= StIdle;
                    tx_serial <= 1'b1;
                    tx_err    <= 1'b1;
                end
            end else if (state != StIdle) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
                case (state)
                    StStart: begin
                        if (baud_wrap) begin
                            state     <= StHeader;
                            tx_serial <= emit_bit;
                            hdr_sr    <= {hdr_sr[HDR_W-2:0], 1'b0};
                            bit_cnt   <= CNT_W'(1);
                        end
                    end
                    StHeader: begin
                        if (baud_wrap) begin
                            if (bit_cnt != CNT_W'(HDR_W)) begin
                                tx_serial <= emit_bit;
                                hdr_sr    <= {hdr_sr[HDR_W-2:0], 1'b0};
                                bit_cnt   <= bit_cnt + 1'b1;
                            end else if (is_data) begin
                                state     <= StPayload;
                                tx_serial <= emit_bit;
                                pay_sr    <= {pay_sr[DATA_W-2:0], 1'b0};
                                bit_cnt   <= CNT_W'(1);
                            end else begin
                                state     <= StCheck;
                                tx_serial <= check_bit;
                                bit_cnt   <= CNT_W'(1);
`ifdef TX_CRC8_EN
                                chk_sr    <= {crc[6:0], 1'b0};
`endif
                            end
                        end
                    end
                    StPayload: begin
                        if (baud_wrap) begin
                            if (bit_cnt != CNT_W'(DATA_W)) begin
                                tx_serial <= emit_bit;
                                pay_sr    <= {pay_sr[DATA_W-2:0], 1'b0};
                                bit_cnt   <= bit_cnt + 1'b1;
                            end else begin
                                state     <= StCheck;
                                tx_serial <= check_bit;
                                bit_cnt   <= CNT_W'(1);
`ifdef TX_CRC8_EN
                                chk_sr    <= {crc[6:0], 1'b0};
`endif
                            end
                        end
                    end
                    StCheck: begin
                        if (baud_wrap) begin
`ifdef TX_CRC8_EN
                            if (bit_cnt != CNT_W'(8)) begin
                                tx_serial <= chk_sr[7];
                                chk_sr    <= {chk_sr[6:0], 1'b0};
                                bit_cnt   <= bit_cnt + 1'b1;
                            end else begin
                                state     <= StStop;
                                tx_serial <= 1'b1;
                            end
`else
                            state     <= StStop;
                            tx_serial <= 1'b1;
`endif
                        end
                    end
                    StStop: begin
                        // Ready during the last stop cycle so a new start bit can follow
                        // the stop bit with no idle gap.
                        if (baud_cnt == BAUD_W'(BIT_DIV - 2)) begin
                            tx_ready <= 1'b1;
                            tx_done  <= 1'b1;
                        end
                        if (baud_wrap) state <= StIdle;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ring_tx_serializer.sv
module tb_ring_tx_serializer;

    localparam logic [3:0]  NODE    = 4'b0001;
    localparam int unsigned DW      = 32;
    localparam int unsigned BIT_DIV = 4;
`ifdef TX_CRC8_EN
    localparam int CHK_BITS = 8;
`else
    localparam int CHK_BITS = 1;
`endif

    typedef struct packed {
        logic [127:0] bits;
        int           len;
    } frame_t;

    logic          Clk_R = 1'b0;
    logic          Rst_n = 1'b0;
    logic          tx_load = 1'b0;
    logic [2:0]    tx_type = 3'b000;
    logic [3:0]    tx_dest = 4'h0;
    logic [DW-1:0] tx_payload = '0;
    logic          tx_ready;
    logic          tx_serial;
    logic          tx_done;
    logic          tx_err;

    int n_checks = 0;
    int n_errors = 0;

    frame_t exp_q[$];

    // Monitor state
    bit           in_frame = 1'b0;
    int           cyc = 0;
    int           nbits = 0;
    int           mlen = 1000;
    int           glitch = 0;
    int           since_end = 1000;
    int           last_gap = 1000;
    int           frames_seen = 0;
    int           done_pulses = 0;
    logic         cur_bit = 1'b1;
    logic [127:0] cap = '0;

    ring_tx_serializer #(
        .NODE_ADDR (NODE),
        .DATA_W    (DW),
        .BIT_DIV   (BIT_DIV)
    ) dut (
        .Clk_R      (Clk_R),
        .Rst_n      (Rst_n),
        .tx_load    (tx_load),
        .tx_type    (tx_type),
        .tx_dest    (tx_dest),
        .tx_payload (tx_payload),
        .tx_ready   (tx_ready),
        .tx_serial  (tx_serial),
        .tx_done    (tx_done),
        .tx_err     (tx_err)
    );

    always #5 Clk_R = ~Clk_R;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference frame: start, checked bits, parity or serial CRC-8 (0x07), stop.
    function automatic frame_t model(input logic [2:0] t, input logic [3:0] d,
                                     input logic [31:0] p);
        frame_t      f;
        logic [10:0] hdr;
        logic        b, fb, par;
        logic [7:0]  c;
        int          cn;
        f.bits = '0;
        f.len  = 0;
        hdr    = {t, d, NODE};
        par    = 1'b0;
        c      = 8'h00;
        cn     = (t == 3'b010 || t == 3'b001) ? 11 + 32 : 11;
        f.bits = {f.bits[126:0], 1'b0};
        f.len++;
        for (int i = 0; i < cn; i++) begin
            b      = (i < 11) ? hdr[10-i] : p[31-(i-11)];
            f.bits = {f.bits[126:0], b};
            f.len++;
            par    = par ^ b;
            fb     = c[7] ^ b;
            c      = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
`ifdef TX_CRC8_EN
        for (int i = 7; i >= 0; i--) begin
            f.bits = {f.bits[126:0], c[i]};
            f.len++;
        end
`else
        f.bits = {f.bits[126:0], par};
        f.len++;
`endif
        f.bits = {f.bits[126:0], 1'b1};
        f.len++;
        return f;
    endfunction

    // Line monitor: captures each frame bit-by-bit and scores it against the queue.
    always @(negedge Clk_R) begin
        frame_t e;
        if (tx_done === 1'b1) done_pulses++;
        if (Rst_n !== 1'b1) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && tx_serial === 1'b0) begin
                in_frame = 1'b1;
                cyc      = 0;
                nbits    = 0;
                cap      = '0;
                mlen     = 1000;
                glitch   = 0;
                last_gap = since_end;
                check("ready_low_at_start", 128'(tx_ready), 128'(1'b0));
            end
            if (in_frame) begin
                if (cyc % BIT_DIV == 0) begin
                    cap     = {cap[126:0], tx_serial};
                    cur_bit = tx_serial;
                    nbits++;
                    if (nbits == 4)
                        mlen = ((cap[2:0] == 3'b010) || (cap[2:0] == 3'b001))
                               ? 13 + CHK_BITS + 32 : 13 + CHK_BITS;
                end else if (tx_serial !== cur_bit) begin
                    glitch++;
                end
                if (cyc == mlen * BIT_DIV - 1) begin
                    check("done_in_last_stop_cycle", 128'(tx_done), 128'(1'b1));
                    check("ready_in_last_stop_cycle", 128'(tx_ready), 128'(1'b1));
                    check("bit_held_bit_div", 128'(glitch), 128'(0));
                    if (exp_q.size() == 0) begin
                        check("unexpected_frame", 128'(exp_q.size()), 128'(1));
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_len", 128'(nbits), 128'(e.len));
                        check("frame_bits", cap, e.bits);
                    end
                    frames_seen++;
                    in_frame  = 1'b0;
                    since_end = 0;
                end else begin
                    cyc++;
                end
            end else begin
                since_end++;
            end
        end
    end

    task automatic send(input logic [2:0] t, input logic [3:0] d, input logic [31:0] p);
        int i;
        for (i = 0; i < 500; i++) begin
            @(negedge Clk_R);
            if (tx_ready === 1'b1) break;
        end
        check("ready_before_send", 128'(tx_ready), 128'(1'b1));
        tx_type    = t;
        tx_dest    = d;
        tx_payload = p;
        tx_load    = 1'b1;
        exp_q.push_back(model(t, d, p));
        @(posedge Clk_R);
        #1 tx_load = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 600; i++) begin
            @(negedge Clk_R);
            if (exp_q.size() == 0 && !in_frame) break;
        end
        check(tag, 128'(exp_q.size()), 128'(0));
        repeat (2) @(negedge Clk_R);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0;
        int acc;

        // Reset state
        repeat (3) @(posedge Clk_R);
        #1;
        check("rst_serial", 128'(tx_serial), 128'(1'b1));
        check("rst_ready", 128'(tx_ready), 128'(1'b1));
        check("rst_done", 128'(tx_done), 128'(1'b0));
        check("rst_err", 128'(tx_err), 128'(1'b0));
        @(negedge Clk_R);
        Rst_n = 1'b1;

        // 1: TOKEN to node 3
        send(3'b111, 4'h3, 32'h0);
        wait_idle("token_complete");
        check("token_done_count", 128'(done_pulses), 128'(1));

        // 2: DATA_C with payload
        send(3'b010, 4'h2, 32'hA5A5_0001);
        wait_idle("data_c_complete");

        // 3: load held high across two ACKs, back-to-back
        f0 = frames_seen;
        @(negedge Clk_R);
        tx_type    = 3'b000;
        tx_dest    = 4'h5;
        tx_payload = 32'hFFFF_FFFF;
        tx_load    = 1'b1;
        exp_q.push_back(model(3'b000, 4'h5, 32'h0));
        exp_q.push_back(model(3'b000, 4'h5, 32'h0));
        acc = 0;
        for (int i = 0; i < 400 && acc < 2; i++) begin
            if (i > 0) @(negedge Clk_R);
            if (tx_ready === 1'b1) acc++;
        end
        @(posedge Clk_R);
        #1 tx_load = 1'b0;
        wait_idle("ack_pair_complete");
        check("ack_pair_frames", 128'(frames_seen - f0), 128'(2));
        check("ack_pair_gap", 128'(last_gap), 128'(0));

        // 4: illegal type
        f0 = frames_seen;
        @(negedge Clk_R);
        tx_type = 3'b100;
        tx_load = 1'b1;
        @(posedge Clk_R);
        #1 tx_load = 1'b0;
        check("illegal_err_pulse", 128'(tx_err), 128'(1'b1));
        check("illegal_ready", 128'(tx_ready), 128'(1'b1));
        check("illegal_serial", 128'(tx_serial), 128'(1'b1));
        @(posedge Clk_R);
        #1;
        check("illegal_err_cleared", 128'(tx_err), 128'(1'b0));
        repeat (20) @(negedge Clk_R);
        check("illegal_no_frame", 128'(frames_seen - f0 + (in_frame ? 1 : 0)), 128'(0));
        check("illegal_line_idle", 128'(tx_serial), 128'(1'b1));

        // 5: reset mid-payload, then a clean frame
        send(3'b001, 4'hC, 32'h1234_5678);
        for (int i = 0; i < 300; i++) begin
            @(negedge Clk_R);
            if (nbits >= 20) break;
        end
        check("reached_payload", 128'(nbits >= 20), 128'(1'b1));
        @(posedge Clk_R);
        #2 Rst_n = 1'b0;
        #1;
        check("midrst_serial", 128'(tx_serial), 128'(1'b1));
        check("midrst_ready", 128'(tx_ready), 128'(1'b1));
        void'(exp_q.pop_front());
        @(negedge Clk_R);
        @(posedge Clk_R);
        #1 Rst_n = 1'b1;
        send(3'b111, 4'h9, 32'h0);
        wait_idle("post_reset_complete");

        // 6: NACK to node 0 (21 bits with CRC build), and a DATA_3 frame
        send(3'b011, 4'h0, 32'h0);
        wait_idle("nack_complete");
        send(3'b001, 4'h7, 32'h8000_00FE);
        wait_idle("data_3_complete");

        check("done_pulses_vs_frames", 128'(done_pulses), 128'(frames_seen));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
